// File: rtl/snake_dir_pkg.sv
// Shared direction definitions for the snake input front-end.
//
// Contents:
//   dir_t        2-bit heading type (Up=0, Down=1, Left=2, Right=3)
//   DIR_*        heading encodings, DIR_RESET is the heading after reset
//   is_opposite  true when two headings point in opposite directions
package snake_dir_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;
  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Opposite pairs share the axis bit [1] and differ in the sign bit [0].
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/dir_queue2.sv
// Two-entry FIFO of headings.
//
// Ports:
//   i_clk    system clock, all state on posedge
//   i_rst_n  asynchronous active-low reset, empties the queue
//   i_push   write i_data at the tail (ignored when full unless popping)
//   i_data   heading to write
//   i_pop    remove the head entry (ignored when empty)
//   o_head   oldest entry
//   o_tail   newest entry
//   o_count  occupancy, 0..2
module dir_queue2
  import snake_dir_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [1:0] i_data,
  input  logic       i_pop,
  output logic [1:0] o_head,
  output logic [1:0] o_tail,
  output logic [1:0] o_count
);

  dir_t       r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  // A pop in the same cycle frees the slot the push needs when full.
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  // Storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  // The write pointer sits one past the newest entry.
  assign o_tail  = r_mem[~r_wr_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/direction_input_scheduler.sv
// Direction-button front-end: samples the four buttons on a shared strobe,
// edge-detects presses, arbitrates, rejects illegal turns and queues up to
// two accepted headings that the game tick consumes one per step.
//
// Ports:
//   i_clk        system clock, all state on posedge
//   i_rst_n      asynchronous active-low reset
//   i_buttons    raw button levels [0]=Up [1]=Down [2]=Left [3]=Right
//   i_step_req   single-cycle request for the next heading
//   o_direction  current heading (Up=0, Down=1, Left=2, Right=3)
//   o_dir_valid  one-cycle pulse after a step that popped a heading
//   o_pending    queued headings, 0..2
//   o_dropped    one-cycle pulse when a press was discarded
module direction_input_scheduler
  import snake_dir_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 20000,
  parameter int CNT_W         = 21
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_buttons,
  input  logic       i_step_req,
  output logic [1:0] o_direction,
  output logic       o_dir_valid,
  output logic [1:0] o_pending,
  output logic       o_dropped
);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_sampled;
  logic [3:0]       r_sampled_prev;
  dir_t             r_dir;
  logic             r_dir_valid;
  logic             r_dropped;

  logic       w_strobe;
  logic [3:0] w_press;
  logic       w_cand_vld;
  dir_t       w_cand;
  logic       w_multi;
  dir_t       w_head;
  dir_t       w_tail;
  logic [1:0] w_count;
  dir_t       w_ref;
  logic       w_pop;
  logic       w_same;
  logic       w_opp;
  logic       w_full_block;
  logic       w_push;
  logic       w_reject;

  // Sampling: one strobe conditions all four buttons together.
  assign w_strobe = (r_cnt == SAMPLE_PERIOD[CNT_W-1:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt          <= '0;
      r_sampled      <= 4'b0000;
      r_sampled_prev <= 4'b0000;
    end else begin
      r_sampled_prev <= r_sampled;
      if (w_strobe) begin
        r_cnt     <= '0;
        r_sampled <= i_buttons;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Edge detect and fixed-priority arbitration (Up > Down > Left > Right).
  assign w_press    = r_sampled & ~r_sampled_prev;
  assign w_cand_vld = |w_press;
  // Clearing the lowest set bit leaves something only if 2+ presses coincide.
  assign w_multi    = (w_press & (w_press - 4'd1)) != 4'd0;

  always_comb begin
    w_cand = DIR_RIGHT;
    if      (w_press[0]) w_cand = DIR_UP;
    else if (w_press[1]) w_cand = DIR_DOWN;
    else if (w_press[2]) w_cand = DIR_LEFT;
  end

  // Turn legality is judged against the heading the snake will have when
  // this candidate is reached: the queue tail, or the live heading if empty.
  assign w_ref        = (w_count != 2'd0) ? w_tail : r_dir;
  assign w_pop        = i_step_req && (w_count != 2'd0);
  assign w_same       = (w_cand == w_ref);
  assign w_opp        = is_opposite(w_cand, w_ref);
  assign w_full_block = (w_count == 2'd2) && !w_pop;
  assign w_push       = w_cand_vld && !w_same && !w_opp && !w_full_block;
  assign w_reject     = w_cand_vld && !w_same && (w_opp || w_full_block);

  dir_queue2 u_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_cand),
    .i_pop   (i_step_req),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count)
  );

  // Output registers: heading update and event pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir       <= DIR_RESET;
      r_dir_valid <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_dir_valid <= w_pop;
      r_dropped   <= w_multi || w_reject;
      if (w_pop) r_dir <= w_head;
    end
  end

  assign o_direction = r_dir;
  assign o_dir_valid = r_dir_valid;
  assign o_pending   = w_count;
  assign o_dropped   = r_dropped;

endmodule

// File: doc/direction_input_scheduler.md
Name: direction_input_scheduler

Overview:
Front-end controller for the snake's four direction buttons. One shared sample-strobe counter conditions all four raw buttons. The block edge-detects presses, arbitrates simultaneous presses, and rejects illegal turns. Accepted turns go into a 2-entry queue, which the game tick drains one heading per step, so quick double-taps (e.g. Up then Left inside one game step) are not lost.

Parameters:
SAMPLE_PERIOD, 20000, strobe asserts when the counter equals this value; effective sample interval is SAMPLE_PERIOD+1 cycles.
CNT_W, 21, sample counter width; must hold SAMPLE_PERIOD.

Ports:
Clock  in  1  system clock; all state on posedge.
ResetN  in  1  asynchronous, active-low reset.
Buttons  in  4  raw button levels: [0]=Up, [1]=Down, [2]=Left, [3]=Right.
StepReq  in  1  single-cycle pulse from the game tick requesting the next heading.
Direction  out  2  current heading: Up=0, Down=1, Left=2, Right=3.
DirValid  out  1  one-cycle pulse, registered, high the cycle after a StepReq that popped an entry.
Pending  out  2  queue occupancy, 0..2.
Dropped  out  1  one-cycle pulse, registered, when a press is discarded (see rules).

Behaviour:
- Reset (async, ResetN=0): counter=0, sampled=0, sampledPrev=0, queue empty, Pending=0, Direction=3 (Right), DirValid=0, Dropped=0. Release takes effect at the next posedge.
- Sample strobe:
  - Counter increments each cycle.
  - When counter==SAMPLE_PERIOD: counter<=0 and sampled[3:0]<=Buttons (all four captured on the same strobe).
  - sampledPrev<=sampled every cycle.
- Press detect: press[i] = sampled[i] & ~sampledPrev[i], combinational. It is high exactly one cycle, the cycle after the strobe edge that captured the rising level.
- Arbitration: fixed priority Up>Down>Left>Right. Only the winner is a candidate. Any additional press bits in the same cycle are discarded and pulse Dropped.
- Reference heading: the queue tail if Pending>0, else Direction. The value used is the pre-update value in that cycle.
- Candidate checks:
  - Same as reference: ignored silently, no Dropped.
  - Opposite of reference (bit1 equal, bit0 differs: Up/Down, Left/Right): rejected, Dropped=1.
  - Pending==2 and no pop this cycle: rejected, Dropped=1.
  - Otherwise: enqueued at the tail.
- StepReq:
  - If Pending>0: Direction<=head, pop, DirValid=1 next cycle.
  - If Pending==0: Direction holds, DirValid stays 0.
- Simultaneous push and pop in one cycle:
  - Both occur; Pending is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, the pop sees empty and the candidate is enqueued, so Pending becomes 1 and Direction is unchanged.
- Latency (button high and stable before strobe edge E):
  - press is high in the cycle after E.
  - Enqueue happens at edge E+1; Pending updates at E+1.
  - Earliest Direction change is at the first StepReq edge after E+1.
- Buttons that stay held generate no further presses. A release followed by a re-press needs one strobe low and one strobe high.
- Reset mid-operation clears the queue and any in-flight press. No DirValid or Dropped pulse is emitted on or after release until a new event occurs.

Decomposition:
- Shared package snake_dir_pkg:
  - direction encoding constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3;
  - DIR_RESET=DIR_RIGHT;
  - an is_opposite(a,b) function;
  - a 2-bit direction typedef.
- One sub-module, dir_queue2: a 2-entry FIFO with push, pop, head, tail, count, and same-cycle push/pop support when full. Strobe, edge detect, arbitration and checks stay in the top module.

Test Plan (SAMPLE_PERIOD=4 in simulation):
- Reset then idle 50 cycles -> Direction=3, Pending=0, DirValid=0, Dropped=0 throughout.
- Hold Buttons=4'b0001 across one strobe, then pulse StepReq -> Pending 0->1 one cycle after the press pulse; DirValid pulses and Direction=0 the cycle after StepReq; Pending=0.
- From Direction=3, press Left (4'b0100) -> Dropped one-cycle pulse, Pending stays 0, Direction stays 3. Press Right -> no Dropped, Pending stays 0.
- From Direction=3, Buttons=4'b0011 on one strobe -> Up enqueued, Down discarded, Dropped pulses once, Pending=1.
- Press Up, then Left, then Down on three separate strobes with no StepReq -> Pending=2, third press Dropped. Then three StepReqs -> Direction goes 0, 2, then holds; DirValid pulses twice only.
- Pending=2 with StepReq coinciding with a press of Up after the tail is Left -> pop and push both occur, Pending stays 2, no Dropped. Then assert ResetN=0 mid-sequence -> Pending=0 and Direction=3 immediately (async).
